// File: rtl/l1_axi_responder_if.sv
// AXI-style bus bundle for the L1 responder: read address/data and
// write address/data/response channels grouped in one interface.
interface l1_axi_responder_if;
    // Read address channel
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] ARADDR;
    logic [7:0]  ARLEN;
    logic [2:0]  ARSIZE;
    // Read data channel
    logic        RVALID;
    logic        RREADY;
    logic [31:0] RDATA;
    logic        RLAST;
    logic        RID;
    logic [1:0]  RRESP;
    // Write address channel
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] AWADDR;
    logic [7:0]  AWLEN;
    logic [2:0]  AWSIZE;
    // Write data channel
    logic        WVALID;
    logic        WREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WLAST;
    // Write response channel
    logic        BVALID;
    logic        BREADY;
    logic        BID;
    logic [1:0]  BRESP;

    modport slave (
        input  ARVALID, ARADDR, ARLEN, ARSIZE,
        output ARREADY,
        output RVALID, RDATA, RLAST, RID, RRESP,
        input  RREADY,
        input  AWVALID, AWADDR, AWLEN, AWSIZE,
        output AWREADY,
        input  WVALID, WDATA, WSTRB, WLAST,
        output WREADY,
        output BVALID, BID, BRESP,
        input  BREADY
    );

    modport master (
        output ARVALID, ARADDR, ARLEN, ARSIZE,
        input  ARREADY,
        input  RVALID, RDATA, RLAST, RID, RRESP,
        output RREADY,
        output AWVALID, AWADDR, AWLEN, AWSIZE,
        input  AWREADY,
        output WVALID, WDATA, WSTRB, WLAST,
        input  WREADY,
        input  BVALID, BID, BRESP,
        output BREADY
    );
endinterface

// File: rtl/l1_axi_responder.sv
// L1 memory responder: 2^DEPTH_LOG2 x 32-bit word store behind independent
// read and write burst engines. Beats past the top of memory return SLVERR
// and never alias into low words; writes there are dropped.
module l1_axi_responder #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst,
    l1_axi_responder_if.slave         s_axi_l1_V,
    output logic                      busy
);

    localparam int          WORDS     = 1 << DEPTH_LOG2;
    localparam logic [31:0] WORDS_32  = 32'd1 << DEPTH_LOG2;
    localparam logic [1:0]  RESP_OKAY = 2'b00;
    localparam logic [1:0]  RESP_SLV  = 2'b10;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rstate_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wstate_t;

    rstate_t     rstate_q;
    logic [31:0] raddr_q;
    logic [7:0]  rcnt_q;

    wstate_t     wstate_q;
    logic [31:0] waddr_q;
    logic        werr_q;

    logic [31:0] mem_q [WORDS];

    logic [31:0] rdata_s;
    logic [1:0]  rresp_s;
    logic        wr_beat_s;
    logic        unused_s;

    // True when the byte address maps onto a physical word (no aliasing).
    function automatic logic in_range(input logic [31:0] addr);
        in_range = (addr >> 2) < WORDS_32;
    endfunction

    // Word index into the storage array; byte offset bits are ignored.
    function automatic logic [DEPTH_LOG2-1:0] word_idx(input logic [31:0] addr);
        word_idx = addr[DEPTH_LOG2+1:2];
    endfunction

    // Size fields are ignored: every beat is a full 32-bit word.
    assign unused_s = ^{s_axi_l1_V.ARSIZE, s_axi_l1_V.AWSIZE};

    // Read engine: accept an address, then stream LEN+1 beats.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            rstate_q <= R_IDLE;
            raddr_q  <= 32'd0;
            rcnt_q   <= 8'd0;
        end else begin
            case (rstate_q)
                R_IDLE: begin
                    if (s_axi_l1_V.ARVALID) begin
                        raddr_q  <= s_axi_l1_V.ARADDR;
                        rcnt_q   <= s_axi_l1_V.ARLEN;
                        rstate_q <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (s_axi_l1_V.RREADY) begin
                        if (rcnt_q == 8'd0) begin
                            rstate_q <= R_IDLE;
                        end else begin
                            raddr_q <= raddr_q + 32'd4;
                            rcnt_q  <= rcnt_q - 8'd1;
                        end
                    end
                end
                default: begin
                    rstate_q <= R_IDLE;
                end
            endcase
        end
    end

    // Current read beat: memory word (pre-write value) or SLVERR with zero data.
    always_comb begin
        rdata_s = 32'd0;
        rresp_s = RESP_OKAY;
        if (rstate_q == R_DATA) begin
            if (in_range(raddr_q)) begin
                rdata_s = mem_q[word_idx(raddr_q)];
            end else begin
                rresp_s = RESP_SLV;
            end
        end else begin
            rdata_s = 32'd0;
            rresp_s = RESP_OKAY;
        end
    end

    assign s_axi_l1_V.ARREADY = (rstate_q == R_IDLE) && !ap_rst;
    assign s_axi_l1_V.RVALID  = (rstate_q == R_DATA);
    assign s_axi_l1_V.RDATA   = rdata_s;
    assign s_axi_l1_V.RRESP   = rresp_s;
    assign s_axi_l1_V.RLAST   = (rstate_q == R_DATA) && (rcnt_q == 8'd0);
    assign s_axi_l1_V.RID     = 1'b0;

    // Write engine: accept an address, absorb beats until WLAST, then respond.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            wstate_q <= W_IDLE;
            waddr_q  <= 32'd0;
            werr_q   <= 1'b0;
        end else begin
            case (wstate_q)
                W_IDLE: begin
                    if (s_axi_l1_V.AWVALID) begin
                        waddr_q  <= s_axi_l1_V.AWADDR;
                        werr_q   <= 1'b0;
                        wstate_q <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (s_axi_l1_V.WVALID) begin
                        if (!in_range(waddr_q)) begin
                            werr_q <= 1'b1;
                        end
                        waddr_q <= waddr_q + 32'd4;
                        if (s_axi_l1_V.WLAST) begin
                            wstate_q <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi_l1_V.BREADY) begin
                        wstate_q <= W_IDLE;
                    end
                end
                default: begin
                    wstate_q <= W_IDLE;
                end
            endcase
        end
    end

    assign wr_beat_s = (wstate_q == W_DATA) && s_axi_l1_V.WVALID && in_range(waddr_q);

    // Byte-lane memory update; contents deliberately survive reset.
    always_ff @(posedge ap_clk) begin
        if (wr_beat_s) begin
            for (int i = 0; i < 4; i++) begin
                if (s_axi_l1_V.WSTRB[i]) begin
                    mem_q[word_idx(waddr_q)][8*i +: 8] <= s_axi_l1_V.WDATA[8*i +: 8];
                end
            end
        end
    end

    assign s_axi_l1_V.AWREADY = (wstate_q == W_IDLE) && !ap_rst;
    assign s_axi_l1_V.WREADY  = (wstate_q == W_DATA);
    assign s_axi_l1_V.BVALID  = (wstate_q == W_RESP);
    assign s_axi_l1_V.BRESP   = (wstate_q == W_RESP) ? (werr_q ? RESP_SLV : RESP_OKAY) : RESP_OKAY;
    assign s_axi_l1_V.BID     = 1'b0;

    assign busy = (rstate_q == R_DATA) || (wstate_q != W_IDLE);

endmodule

// File: tb/tb_l1_axi_responder.sv
// Self-checking bench for l1_axi_responder: directed table, hand-written
// corner sequences and randomized bursts against a word-array model.
module tb_l1_axi_responder;

    logic ap_clk = 1'b0;
    logic ap_rst = 1'b1;
    logic busy;

    l1_axi_responder_if axi();

    l1_axi_responder #(.DEPTH_LOG2(10)) dut (
        .ap_clk     (ap_clk),
        .ap_rst     (ap_rst),
        .s_axi_l1_V (axi),
        .busy       (busy)
    );

    always #5 ap_clk = ~ap_clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] mdl [1024];
    logic [31:0] wd  [1024];
    logic [3:0]  ws  [1024];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] pre;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_rd;
        logic [1:0]  exp_b;
        logic [1:0]  exp_r;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge ap_clk);
        #1;
    endtask

    function automatic bit mdl_inr(input logic [31:0] a);
        return (a >> 2) < 32'd1024;
    endfunction

    task automatic do_write(input logic [31:0] addr, input int n, input bit rnd, output logic [1:0] bresp);
        logic [31:0] a;
        bit err;
        int guard;
        int d;
        axi.AWVALID = 1'b1;
        axi.AWADDR  = addr;
        axi.AWLEN   = 8'(n - 1);
        axi.AWSIZE  = 3'd2;
        guard = 0;
        while (axi.AWREADY !== 1'b1 && guard < 20) begin
            cycle();
            guard++;
        end
        chk("aw_ready", {31'd0, axi.AWREADY}, 32'd1);
        cycle();
        axi.AWVALID = 1'b0;
        a = addr;
        err = 1'b0;
        for (int b = 0; b < n; b++) begin
            if (rnd && $urandom_range(0, 3) == 0) begin
                axi.WVALID = 1'b0;
                cycle();
            end
            axi.WVALID = 1'b1;
            axi.WDATA  = wd[b];
            axi.WSTRB  = ws[b];
            axi.WLAST  = (b == n - 1);
            chk("w_ready", {31'd0, axi.WREADY}, 32'd1);
            if (mdl_inr(a)) begin
                for (int i = 0; i < 4; i++) begin
                    if (ws[b][i]) mdl[a[11:2]][8*i +: 8] = wd[b][8*i +: 8];
                end
            end else begin
                err = 1'b1;
            end
            a = a + 32'd4;
            cycle();
        end
        axi.WVALID = 1'b0;
        axi.WLAST  = 1'b0;
        chk("b_valid", {31'd0, axi.BVALID}, 32'd1);
        d = rnd ? int'($urandom_range(0, 3)) : 0;
        for (int k = 0; k < d; k++) begin
            cycle();
            chk("b_hold", {31'd0, axi.BVALID}, 32'd1);
        end
        axi.BREADY = 1'b1;
        bresp = axi.BRESP;
        chk("b_resp", {30'd0, axi.BRESP}, err ? 32'd2 : 32'd0);
        chk("b_id", {31'd0, axi.BID}, 32'd0);
        cycle();
        axi.BREADY = 1'b0;
        chk("b_done", {31'd0, axi.BVALID}, 32'd0);
        chk("aw_ready_after", {31'd0, axi.AWREADY}, 32'd1);
    endtask

    task automatic do_read(input logic [31:0] addr, input int len, input logic [31:0] pat,
                           input int npat, input bit rnd,
                           output logic [31:0] last_d, output logic [1:0] last_r);
        logic [31:0] a;
        int guard;
        int k;
        int stall;
        bit rr;
        bit acc;
        bit inr;
        axi.ARVALID = 1'b1;
        axi.ARADDR  = addr;
        axi.ARLEN   = 8'(len);
        axi.ARSIZE  = 3'd2;
        guard = 0;
        while (axi.ARREADY !== 1'b1 && guard < 20) begin
            cycle();
            guard++;
        end
        chk("ar_ready", {31'd0, axi.ARREADY}, 32'd1);
        cycle();
        axi.ARVALID = 1'b0;
        a = addr;
        k = 0;
        last_d = 32'd0;
        last_r = 2'd0;
        for (int b = 0; b <= len; b++) begin
            acc = 1'b0;
            stall = 0;
            while (!acc) begin
                if (k < npat) rr = pat[k];
                else if (rnd && stall < 3) rr = 1'($urandom_range(0, 1));
                else rr = 1'b1;
                k++;
                axi.RREADY = rr;
                inr = mdl_inr(a);
                chk("r_valid", {31'd0, axi.RVALID}, 32'd1);
                chk("r_data", axi.RDATA, inr ? mdl[a[11:2]] : 32'd0);
                chk("r_resp", {30'd0, axi.RRESP}, inr ? 32'd0 : 32'd2);
                chk("r_last", {31'd0, axi.RLAST}, (b == len) ? 32'd1 : 32'd0);
                last_d = axi.RDATA;
                last_r = axi.RRESP;
                cycle();
                if (rr) acc = 1'b1;
                else stall++;
            end
            a = a + 32'd4;
        end
        axi.RREADY = 1'b0;
        chk("r_end", {31'd0, axi.RVALID}, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [1:0]  rr;
        logic [1:0]  br;

        axi.ARVALID = 1'b0; axi.ARADDR = 32'd0; axi.ARLEN = 8'd0; axi.ARSIZE = 3'd2;
        axi.RREADY  = 1'b0;
        axi.AWVALID = 1'b0; axi.AWADDR = 32'd0; axi.AWLEN = 8'd0; axi.AWSIZE = 3'd2;
        axi.WVALID  = 1'b0; axi.WDATA = 32'd0; axi.WSTRB = 4'd0; axi.WLAST = 1'b0;
        axi.BREADY  = 1'b0;

        vecs[0] = '{32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 4'hF, 32'hDEAD_BEEF, 2'd0, 2'd0};
        vecs[1] = '{32'h0000_0000, 32'h1122_3344, 32'hAABB_CCDD, 4'b0101, 32'h11BB_33DD, 2'd0, 2'd0};
        vecs[2] = '{32'h0000_0004, 32'hFFFF_FFFF, 32'h0000_0000, 4'b1010, 32'h00FF_00FF, 2'd0, 2'd0};
        vecs[3] = '{32'h0000_0FFE, 32'h0102_0304, 32'h0A0B_0C0D, 4'b1000, 32'h0A02_0304, 2'd0, 2'd0};
        vecs[4] = '{32'h0000_1000, 32'h1234_5678, 32'h8765_4321, 4'hF, 32'h0000_0000, 2'd2, 2'd2};
        vecs[5] = '{32'hFFFF_FFFC, 32'h5555_5555, 32'hAAAA_AAAA, 4'hF, 32'h0000_0000, 2'd2, 2'd2};

        // Reset state
        repeat (3) cycle();
        chk("rst_arready", {31'd0, axi.ARREADY}, 32'd0);
        chk("rst_awready", {31'd0, axi.AWREADY}, 32'd0);
        chk("rst_wready",  {31'd0, axi.WREADY},  32'd0);
        chk("rst_rvalid",  {31'd0, axi.RVALID},  32'd0);
        chk("rst_bvalid",  {31'd0, axi.BVALID},  32'd0);
        chk("rst_rlast",   {31'd0, axi.RLAST},   32'd0);
        chk("rst_busy",    {31'd0, busy},        32'd0);
        chk("rst_rresp",   {30'd0, axi.RRESP},   32'd0);
        chk("rst_bresp",   {30'd0, axi.BRESP},   32'd0);
        chk("rst_rdata",   axi.RDATA,            32'd0);
        ap_rst = 1'b0;
        #1;
        chk("post_rst_arready", {31'd0, axi.ARREADY}, 32'd1);
        chk("post_rst_awready", {31'd0, axi.AWREADY}, 32'd1);
        cycle();

        // Fill all of memory with known random data in one long burst
        for (int i = 0; i < 1024; i++) begin
            wd[i] = $urandom;
            ws[i] = 4'hF;
        end
        do_write(32'd0, 1024, 1'b0, br);

        // Directed table: pre-fill, strobed write, single-beat read back
        for (int v = 0; v < 6; v++) begin
            wd[0] = vecs[v].pre;  ws[0] = 4'hF;
            do_write(vecs[v].addr, 1, 1'b0, br);
            wd[0] = vecs[v].data; ws[0] = vecs[v].strb;
            do_write(vecs[v].addr, 1, 1'b0, br);
            chk("tbl_bresp", {30'd0, br}, {30'd0, vecs[v].exp_b});
            do_read(vecs[v].addr, 0, 32'd0, 0, 1'b0, rd, rr);
            chk("tbl_rdata", rd, vecs[v].exp_rd);
            chk("tbl_rresp", {30'd0, rr}, {30'd0, vecs[v].exp_r});
        end
        // Out-of-range writes left word 0 untouched
        do_read(32'd0, 0, 32'd0, 0, 1'b0, rd, rr);
        chk("oor_no_alias", rd, 32'h11BB_33DD);

        // Four-beat read with RREADY pattern 1,0,1,1,0,1
        for (int i = 0; i < 4; i++) begin
            wd[i] = 32'(i + 1);
            ws[i] = 4'hF;
        end
        do_write(32'h10, 4, 1'b0, br);
        do_read(32'h10, 3, 32'b101101, 6, 1'b0, rd, rr);
        chk("stall_last_data", rd, 32'd4);

        // Read crossing the top of memory
        do_read(32'hFF8, 3, 32'd0, 0, 1'b0, rd, rr);
        chk("top_last_resp", {30'd0, rr}, 32'd2);
        chk("top_last_data", rd, 32'd0);

        // Same-cycle write and read of one word
        wd[0] = 32'h44; ws[0] = 4'hF;
        do_write(32'h20, 1, 1'b0, br);
        axi.AWVALID = 1'b1; axi.AWADDR = 32'h20; axi.AWLEN = 8'd0;
        axi.ARVALID = 1'b1; axi.ARADDR = 32'h20; axi.ARLEN = 8'd0;
        chk("cc_awready", {31'd0, axi.AWREADY}, 32'd1);
        chk("cc_arready", {31'd0, axi.ARREADY}, 32'd1);
        cycle();
        axi.AWVALID = 1'b0; axi.ARVALID = 1'b0;
        axi.WVALID = 1'b1; axi.WDATA = 32'h55; axi.WSTRB = 4'hF; axi.WLAST = 1'b1;
        axi.RREADY = 1'b1;
        chk("cc_wready", {31'd0, axi.WREADY}, 32'd1);
        chk("cc_old_data", axi.RDATA, 32'h44);
        cycle();
        axi.WVALID = 1'b0; axi.WLAST = 1'b0; axi.RREADY = 1'b0;
        chk("cc_rdone", {31'd0, axi.RVALID}, 32'd0);
        chk("cc_bvalid", {31'd0, axi.BVALID}, 32'd1);
        axi.BREADY = 1'b1;
        chk("cc_bresp", {30'd0, axi.BRESP}, 32'd0);
        cycle();
        axi.BREADY = 1'b0;
        mdl[8] = 32'h55;
        do_read(32'h20, 0, 32'd0, 0, 1'b0, rd, rr);
        chk("cc_new_data", rd, 32'h55);

        // Reset during beat 2 of an eight-beat read
        axi.ARVALID = 1'b1; axi.ARADDR = 32'h40; axi.ARLEN = 8'd7;
        cycle();
        axi.ARVALID = 1'b0;
        axi.RREADY = 1'b1;
        chk("rr_beat1", axi.RDATA, mdl[16]);
        cycle();
        chk("rr_beat2", axi.RDATA, mdl[17]);
        ap_rst = 1'b1;
        #1;
        chk("rr_rvalid", {31'd0, axi.RVALID}, 32'd0);
        chk("rr_arready", {31'd0, axi.ARREADY}, 32'd0);
        chk("rr_busy", {31'd0, busy}, 32'd0);
        chk("rr_rdata", axi.RDATA, 32'd0);
        cycle();
        cycle();
        ap_rst = 1'b0;
        #1;
        chk("rr_arready_after", {31'd0, axi.ARREADY}, 32'd1);
        chk("rr_awready_after", {31'd0, axi.AWREADY}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            chk("rr_no_beats", {31'd0, axi.RVALID}, 32'd0);
            cycle();
        end
        axi.RREADY = 1'b0;

        // Randomized bursts, many crossing the top of memory
        for (int t = 0; t < 60; t++) begin
            logic [31:0] ra;
            int n;
            ra = $urandom_range(0, 32'h1020);
            if ($urandom_range(0, 1) == 1) begin
                n = $urandom_range(1, 6);
                for (int i = 0; i < n; i++) begin
                    wd[i] = $urandom;
                    ws[i] = 4'($urandom_range(0, 15));
                end
                do_write(ra, n, 1'b1, br);
            end else begin
                do_read(ra, $urandom_range(0, 7), 32'd0, 0, 1'b1, rd, rr);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
